// File: rtl/regb_fifo_arbiter_if.sv
// Producer/consumer bus of the register-based FIFO arbiter.
// The almost_full signal exists only when REGB_ARB_AF_EN is defined.
interface regb_fifo_arbiter_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NREQ  = 4
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       gnt;
  logic                  rd_req;
  logic [WIDTH-1:0]      fifo_si;
  logic                  fifo_shift_in;
  logic                  fifo_shift_out;
  logic [CntW-1:0]       count;
  logic                  empty_n;
  logic                  full;
`ifdef REGB_ARB_AF_EN
  logic                  almost_full;

  modport slave (
    input  req, data_in, rd_req,
    output gnt, fifo_si, fifo_shift_in, fifo_shift_out, count, empty_n, full, almost_full
  );
  modport master (
    output req, data_in, rd_req,
    input  gnt, fifo_si, fifo_shift_in, fifo_shift_out, count, empty_n, full, almost_full
  );
`else
  modport slave (
    input  req, data_in, rd_req,
    output gnt, fifo_si, fifo_shift_in, fifo_shift_out, count, empty_n, full
  );
  modport master (
    output req, data_in, rd_req,
    input  gnt, fifo_si, fifo_shift_in, fifo_shift_out, count, empty_n, full
  );
`endif
endinterface

// File: rtl/regb_fifo_arbiter.sv
// Round-robin write arbiter and occupancy tracker for the register-based FIFO chain.
// Optional registered almost_full flag enabled by defining REGB_ARB_AF_EN.
module regb_fifo_arbiter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned AF_LEVEL = 3
) (
  input  logic               clk_i,
  input  logic               res_i,
  regb_fifo_arbiter_if.slave bus
);
  localparam int unsigned PtrW = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || DEPTH > 16 || NREQ < 2 || NREQ > 8 || AF_LEVEL > DEPTH) begin : g_bad_params
    $error("regb_fifo_arbiter: parameter out of range");
  end

  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             empty_n_q, full_q;
  logic [NREQ-1:0]  gnt;
  logic [WIDTH-1:0] si;
  logic             found;
  logic             shift_in, shift_out;
  int unsigned      idx;

  // Grant depends only on registered full, so rd_req never reaches gnt.
  always_comb begin
    gnt   = '0;
    si    = '0;
    found = 1'b0;
    idx   = 0;
    ptr_d = ptr_q;
    if (!res_i && !full_q) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = (32'(ptr_q) + k) % NREQ;
        if (!found && bus.req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          si       = bus.data_in[idx*WIDTH +: WIDTH];
          ptr_d    = PtrW'((idx + 1) % NREQ);
        end
      end
    end
  end

  assign shift_in  = |gnt;
  assign shift_out = bus.rd_req & empty_n_q & ~res_i;

  always_comb begin
    count_d = count_q;
    unique case ({shift_in, shift_out})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      ptr_q     <= '0;
      count_q   <= '0;
      empty_n_q <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      empty_n_q <= (count_d != '0);
      full_q    <= (count_d == CntW'(DEPTH));
    end
  end

`ifdef REGB_ARB_AF_EN
  logic almost_full_q;

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= (count_d >= CntW'(AF_LEVEL));
    end
  end

  assign bus.almost_full = almost_full_q;
`endif

  assign bus.gnt            = gnt;
  assign bus.fifo_si        = si;
  assign bus.fifo_shift_in  = shift_in;
  assign bus.fifo_shift_out = shift_out;
  assign bus.count          = count_q;
  assign bus.empty_n        = empty_n_q;
  assign bus.full           = full_q;

endmodule

// File: tb/tb_regb_fifo_arbiter.sv
// Table-driven bench for regb_fifo_arbiter (NREQ=4, DEPTH=4, WIDTH=4), plus corner sequences.
module tb_regb_fifo_arbiter;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NREQ  = 4;

  typedef struct {
    logic       res;
    logic [3:0] req;
    logic       rd;
    logic [3:0] gnt;
    logic [3:0] si;
    logic       shin;
    logic       shout;
    logic [2:0] cnt;
    logic       en;
    logic       full;
  } vec_t;

  logic clk = 1'b0;
  logic res;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vq[$];

  regb_fifo_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) bus ();

  regb_fifo_arbiter #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ), .AF_LEVEL(3)
  ) dut (
    .clk_i(clk),
    .res_i(res),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Slice i carries 0xA + i so each grant is identifiable on fifo_si.
  assign bus.data_in = 16'hDCBA;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic rd, input logic [3:0] g,
                     input logic [3:0] s, input logic si_, input logic so, input logic [2:0] c,
                     input logic e, input logic f);
    vec_t v;
    v.res = r; v.req = rq; v.rd = rd; v.gnt = g; v.si = s; v.shin = si_; v.shout = so;
    v.cnt = c; v.en = e; v.full = f;
    vq.push_back(v);
  endtask

  initial begin
    res        = 1'b1;
    bus.req    = 4'b1111;
    bus.rd_req = 1'b1;

    //  res req     rd gnt     si    in so cnt en full
    add(1, 4'b1111, 1, 4'b0000, 4'h0, 0, 0, 0, 0, 0);  // reset, cycle 1
    add(1, 4'b1111, 1, 4'b0000, 4'h0, 0, 0, 0, 0, 0);  // reset, cycle 2
    add(0, 4'b1011, 1, 4'b0001, 4'hA, 1, 0, 0, 0, 0);  // round robin
    add(0, 4'b1011, 1, 4'b0010, 4'hB, 1, 1, 1, 1, 0);
    add(0, 4'b1011, 1, 4'b1000, 4'hD, 1, 1, 1, 1, 0);
    add(0, 4'b0000, 1, 4'b0000, 4'h0, 0, 1, 1, 1, 0);  // drain
    add(0, 4'b0001, 0, 4'b0001, 4'hA, 1, 0, 0, 0, 0);  // fill to full
    add(0, 4'b0001, 0, 4'b0001, 4'hA, 1, 0, 1, 1, 0);
    add(0, 4'b0001, 0, 4'b0001, 4'hA, 1, 0, 2, 1, 0);
    add(0, 4'b0001, 0, 4'b0001, 4'hA, 1, 0, 3, 1, 0);
    add(0, 4'b0001, 0, 4'b0000, 4'h0, 0, 0, 4, 1, 1);  // full blocks write
    add(0, 4'b0001, 1, 4'b0000, 4'h0, 0, 1, 4, 1, 1);  // full plus read
    add(0, 4'b0000, 0, 4'b0000, 4'h0, 0, 0, 3, 1, 0);
    add(0, 4'b0000, 1, 4'b0000, 4'h0, 0, 1, 3, 1, 0);
    add(0, 4'b0000, 1, 4'b0000, 4'h0, 0, 1, 2, 1, 0);
    add(0, 4'b0000, 1, 4'b0000, 4'h0, 0, 1, 1, 1, 0);
    add(0, 4'b0000, 1, 4'b0000, 4'h0, 0, 0, 0, 0, 0);  // empty read ignored
    add(0, 4'b0000, 0, 4'b0000, 4'h0, 0, 0, 0, 0, 0);
    add(0, 4'b0100, 1, 4'b0100, 4'hC, 1, 0, 0, 0, 0);  // write+read at 0
    add(0, 4'b0100, 1, 4'b0100, 4'hC, 1, 1, 1, 1, 0);  // write+read at 1
    add(0, 4'b0000, 0, 4'b0000, 4'h0, 0, 0, 1, 1, 0);
    add(1, 4'b1111, 1, 4'b0000, 4'h0, 0, 0, 1, 1, 0);  // mid-operation reset
    add(0, 4'b1111, 0, 4'b0001, 4'hA, 1, 0, 0, 0, 0);  // ptr restarted at 0

    foreach (vq[i]) begin
      @(negedge clk);
      res        = vq[i].res;
      bus.req    = vq[i].req;
      bus.rd_req = vq[i].rd;
      #1;
      chk("gnt", i, 32'(bus.gnt), 32'(vq[i].gnt));
      chk("fifo_si", i, 32'(bus.fifo_si), 32'(vq[i].si));
      chk("shift_in", i, 32'(bus.fifo_shift_in), 32'(vq[i].shin));
      chk("shift_out", i, 32'(bus.fifo_shift_out), 32'(vq[i].shout));
      chk("count", i, 32'(bus.count), 32'(vq[i].cnt));
      chk("empty_n", i, 32'(bus.empty_n), 32'(vq[i].en));
      chk("full", i, 32'(bus.full), 32'(vq[i].full));
    end

    // Starvation bound: count=1, ptr=1 now; producer 3 must win within NREQ grants.
    begin
      int waited = 0;
      logic got  = 1'b0;
      while (!got && waited < int'(NREQ)) begin
        @(negedge clk);
        bus.req    = 4'b1111;
        bus.rd_req = 1'b1;
        #1;
        if (bus.gnt[3]) got = 1'b1;
        waited++;
      end
      chk("starve_bound", 0, 32'(got), 32'd1);
      chk("starve_wait", 0, 32'(waited), 32'd3);
    end

`ifdef REGB_ARB_AF_EN
    @(negedge clk);
    res = 1'b1; bus.req = 4'b0000; bus.rd_req = 1'b0;
    @(negedge clk);
    res = 1'b0;
    #1;
    chk("af_reset", 0, 32'(bus.almost_full), 32'd0);
    for (int w = 1; w <= 3; w++) begin
      @(negedge clk);
      bus.req = 4'b0001;
      @(negedge clk);
      bus.req = 4'b0000;
      #1;
      chk("af_count", w, 32'(bus.count), 32'(w));
      chk("af_level", w, 32'(bus.almost_full), (w >= 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    bus.rd_req = 1'b1;
    @(negedge clk);
    bus.rd_req = 1'b0;
    #1;
    chk("af_fall_count", 0, 32'(bus.count), 32'd2);
    chk("af_fall", 0, 32'(bus.almost_full), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regb_fifo_arbiter.md
# regb_fifo_arbiter

Round-robin write arbiter and occupancy controller for the shared register-based FIFO chain. It selects one of NREQ producers per cycle and drives the chain's `si`/`shift_in`. It gates the consumer's read request into `shift_out` and tracks fill level to produce full/empty status. It sits between the producer ports and the FIFO chain, so the chain itself never sees an illegal shift.

## Interface
- `WIDTH`, default 4: data word width; must match the FIFO chain.
- `DEPTH`, default 4: number of chain stages; valid range 2..16.
- `NREQ`, default 4: number of producers; valid range 2..8.
- `AF_LEVEL`, default 3: almost-full threshold; used only with `REGB_ARB_AF_EN`.

Ports:
- `clk`  in  1  rising-edge clock, the only clock
- `res`  in  1  synchronous, active-high reset
- `req`  in  NREQ  per-producer write request; bit i belongs to producer i
- `data_in`  in  NREQ*WIDTH  producer data; slice i is `[i*WIDTH +: WIDTH]`
- `gnt`  out  NREQ  one-hot grant; the write of producer i is accepted in a cycle where `gnt[i]`=1
- `rd_req`  in  1  consumer read request
- `fifo_si`  out  WIDTH  data to the chain head; equals the granted slice, otherwise 0
- `fifo_shift_in`  out  1  chain shift-in strobe
- `fifo_shift_out`  out  1  chain shift-out strobe
- `count`  out  $clog2(DEPTH+1)  current occupancy
- `empty_n`  out  1  1 when `count`≠0
- `full`  out  1  1 when `count`==DEPTH
- `almost_full`  out  1  present only with `REGB_ARB_AF_EN`

## Operation
**Arbitration**
- The arbiter is combinational from `req`, pointer `ptr`, `full` and `res`.
- The search starts at index `ptr` and ascends modulo NREQ. The first asserted `req` receives `gnt`.
- `gnt` is all-zero when `full`=1, when `res`=1, or when `req`=0.
- `ptr` register:
  - on a grant to index i, `ptr` becomes (i+1) mod NREQ at the next edge;
  - with no grant, `ptr` holds.
- `fifo_shift_in` = OR of `gnt`.
- `fifo_si` = `data_in` slice of the granted index, otherwise 0.

**Read side**
- `fifo_shift_out` = `rd_req` AND `empty_n` AND NOT `res`.
- A read on an empty FIFO is ignored: no strobe and no count change.

**Occupancy counter**
- Update at each clock edge, based on the strobes:
  - shift_in only: `count`+1;
  - shift_out only: `count`−1;
  - both or neither: `count` holds.
- `count` never exceeds DEPTH and never goes below 0. Gating of the strobes guarantees this.
- Full blocks writes even if a read occurs in the same cycle. This is intentional: it keeps the path from `rd_req` to `gnt` free.
- `empty_n` and `full` are registered, updated together with `count`.

**Reset**
- When `res`=1 at an edge:
  - `count`=0, `ptr`=0, `empty_n`=0, `full`=0, `almost_full`=0;
  - `gnt`, `fifo_shift_in` and `fifo_shift_out` are forced to 0 combinationally while `res`=1.
- Reset asserted mid-operation discards the occupancy tracking. The chain must be reset by the same `res` source in the same cycle.

## Timing
- Grant latency: 0 cycles. `gnt` is valid in the same cycle as `req`, and the data is captured by the chain at the next edge.
- `count`, `empty_n` and `full` reflect a strobe one cycle after it.
- Read latency from the chain tail: the word is valid while `empty_n`=1. `rd_req` consumes it at the edge.
- Simultaneous write and read at `count`=1: `count` stays 1 and `empty_n` stays 1.
- Simultaneous write and read at `count`=0: only the write is performed; `count` becomes 1.
- A producer holding `req` waits at most NREQ−1 grant cycles. `ptr` wraps from NREQ−1 to 0.

## Configuration
- `REGB_ARB_AF_EN` defined:
  - adds output `almost_full`, a registered flag equal to (`count` ≥ AF_LEVEL);
  - it updates in the same cycle as `count` and has reset value 0.
- Without the macro, the port and its logic are absent and everything else is identical.

## Test plan
- Reset check: assert `res` for 2 cycles with `req`=4'b1111 and `rd_req`=1.
  - Required: `gnt`=0, both strobes 0, `count`=0, `empty_n`=0, `full`=0.
- Round robin: with NREQ=4, hold `req`=4'b1011 for 3 cycles and `rd_req`=1.
  - Required: `gnt` sequence 0001, 0010, 1000.
  - `fifo_si` equals each granted slice in turn.
- Fill to full: `req`=4'b0001 continuously and `rd_req`=0, DEPTH=4.
  - Required: `count` steps 1, 2, 3, 4; `full`=1 after the 4th write; `gnt`=0 thereafter.
- Full plus read: at `count`=4, drive `req`=1 and `rd_req`=1.
  - Required: `gnt`=0 and `fifo_shift_out`=1; `count`=3 next cycle.
- Empty read: at `count`=0, drive `rd_req`=1 and `req`=0.
  - Required: `fifo_shift_out`=0; `count` stays 0.
- Almost full: with `REGB_ARB_AF_EN` and AF_LEVEL=3, fill to 3.
  - Required: `almost_full` rises in the same cycle `count`=3 and falls when `count` returns to 2.
